// File: rtl/crc5_arbiter_if.sv
// Requester and crc5-engine signals shared by the arbiter and its environment.
// The arbiter sits on the master side; requesters and the engine stub use slave.
interface crc5_arbiter_if #(
    parameter int NREQ   = 2,
    parameter int DATA_W = 11
);
    logic [NREQ-1:0]        req;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        done;
    logic [4:0]             crc_out;
    logic                   err;
    logic                   crc5_start;
    logic                   s_in;
    logic                   crc5_rec;
    logic                   crc5_out;
    logic                   crc5_ready;
    logic                   crc5_done;

    modport master (
        input  req, req_data, crc5_out, crc5_ready, crc5_done,
        output gnt, done, crc_out, err, crc5_start, s_in, crc5_rec
    );

    modport slave (
        output req, req_data, crc5_out, crc5_ready, crc5_done,
        input  gnt, done, crc_out, err, crc5_start, s_in, crc5_rec
    );
endinterface

// File: rtl/crc5_arbiter.sv
// Round-robin arbiter sharing one serial crc5 engine between NREQ requesters.
// States: IDLE arbitrate | START kick engine | FEED shift field out | WAIT_RDY/COLLECT
// capture 5 CRC bits | WAIT_DONE engine finish | RELEASE/ABORT free engine | RESP done pulse.
module crc5_arbiter #(
    parameter int NREQ    = 2,
    parameter int DATA_W  = 11,
    parameter int TIMEOUT = 32
) (
    input  logic           clk,
    input  logic           rst,
    crc5_arbiter_if.master bus
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = $clog2(DATA_W);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_FEED, S_WAIT_RDY, S_COLLECT,
        S_WAIT_DONE, S_RELEASE, S_RESP, S_ABORT
    } state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   pick;
    logic               any_req;
    int                 arb_idx;
    logic [NREQ-1:0]    gnt_r;
    logic [DATA_W-1:0]  shreg;
    logic [CNT_W-1:0]   bit_cnt;
    logic [WD_W-1:0]    wdog;
    logic [2:0]         crc_cnt;
    logic [4:0]         crc_sh;
    logic [4:0]         crc_r;
    logic               err_r;
    logic               wd_exp;
    logic               feed_last;

    assign wd_exp    = (wdog == WD_W'(TIMEOUT - 1));
    assign feed_last = (bit_cnt == CNT_W'(DATA_W - 1));
    assign bus.gnt     = gnt_r;
    assign bus.crc_out = crc_r;

    // First set request after the last winner, wrapping around.
    always_comb begin
        pick    = ptr;
        any_req = 1'b0;
        arb_idx = 0;
        for (int k = 1; k <= NREQ; k++) begin
            arb_idx = (int'(ptr) + k) % NREQ;
            if (!any_req && bus.req[arb_idx]) begin
                any_req = 1'b1;
                pick    = PTR_W'(arb_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        bus.crc5_start = 1'b0;
        bus.s_in       = 1'b0;
        bus.crc5_rec   = 1'b0;
        bus.done       = '0;
        bus.err        = 1'b0;
        case (state)
            S_IDLE:      if (any_req) state_nxt = S_START;
            S_START: begin
                bus.crc5_start = 1'b1;
                state_nxt      = S_FEED;
            end
            S_FEED: begin
                bus.s_in = shreg[bit_cnt];
                if (feed_last) state_nxt = S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
                if (bus.crc5_ready) state_nxt = S_COLLECT;
                else if (wd_exp)    state_nxt = S_ABORT;
            end
            S_COLLECT: begin
                if (bus.crc5_ready && crc_cnt == 3'd4) state_nxt = S_WAIT_DONE;
                else if (!bus.crc5_ready && wd_exp)    state_nxt = S_ABORT;
            end
            S_WAIT_DONE: begin
                if (bus.crc5_done) state_nxt = S_RELEASE;
                else if (wd_exp)   state_nxt = S_ABORT;
            end
            S_RELEASE: begin
                bus.crc5_rec = 1'b1;
                state_nxt    = S_RESP;
            end
            S_RESP: begin
                bus.done  = gnt_r;
                bus.err   = err_r;
                state_nxt = S_IDLE;
            end
            S_ABORT: begin
                bus.crc5_rec = 1'b1;
                state_nxt    = S_RESP;
            end
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= PTR_W'(NREQ - 1);
            gnt_r   <= '0;
            shreg   <= '0;
            bit_cnt <= '0;
            wdog    <= '0;
            crc_cnt <= '0;
            crc_sh  <= '0;
            crc_r   <= '0;
            err_r   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (any_req) begin
                    ptr     <= pick;
                    gnt_r   <= NREQ'(1) << pick;
                    shreg   <= bus.req_data[int'(pick)*DATA_W +: DATA_W];
                    bit_cnt <= '0;
                    crc_cnt <= '0;
                    err_r   <= 1'b0;
                end
                S_FEED: begin
                    bit_cnt <= bit_cnt + 1'b1;
                    if (feed_last) wdog <= '0;
                end
                S_WAIT_RDY, S_COLLECT: begin
                    if (bus.crc5_ready) begin
                        crc_sh  <= {crc_sh[3:0], bus.crc5_out};
                        crc_cnt <= crc_cnt + 1'b1;
                        // Fresh watchdog window for the engine's finish phase.
                        if (crc_cnt == 3'd4) wdog <= '0;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                S_WAIT_DONE: if (!bus.crc5_done) wdog <= wdog + 1'b1;
                S_RELEASE:   crc_r <= crc_sh;
                S_ABORT: begin
                    crc_r <= '0;
                    err_r <= 1'b1;
                end
                S_RESP:      gnt_r <= '0;
                default: ;
            endcase
        end
    end
endmodule

// File: doc/crc5_arbiter.md
Name: crc5_arbiter

Overview:
- Sequencer and round-robin arbiter that shares one crc5 engine between NREQ requesters (token builders, receive checkers).
- Latches the winner's 11-bit field (7-bit addr + 4-bit endp) and pulses crc5_start.
- Feeds the field serially on s_in, captures the 5 serial CRC bits while crc5_ready is high, then releases the engine with crc5_rec.
- Returns the CRC to the granted requester with a done pulse, and guards every engine wait with a watchdog.

Parameters:
- NREQ, 2, number of requesters (2..8).
- DATA_W, 11, field width fed to the engine; must equal 11 to match the engine's internal count.
- TIMEOUT, 32, max cycles spent in WAIT_RDY or WAIT_DONE before abort.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- req  in  NREQ  per-requester request level; held until matching done.
- req_data  in  NREQ*DATA_W  field for requester i in bits [i*DATA_W +: DATA_W].
- gnt  out  NREQ  one-hot grant; high for the whole transaction.
- done  out  NREQ  one-cycle completion pulse to the granted requester.
- crc_out  out  5  captured CRC; valid while done is high, then held.
- err  out  1  one-cycle pulse coincident with done on watchdog abort.
- crc5_start  out  1  engine start pulse.
- s_in  out  1  engine serial data.
- crc5_rec  out  1  engine release pulse.
- crc5_out  in  1  engine serial CRC bit.
- crc5_ready  in  1  engine CRC-bit-valid strobe.
- crc5_done  in  1  engine finished/holding.

Behaviour:
- Single clock domain: clk.
- Reset: synchronous, active-high rst; the engine's rst_n is tied to ~rst at integration.
- On reset:
  - state=IDLE.
  - gnt=0, done=0, err=0, crc_out=0.
  - crc5_start=0, s_in=0, crc5_rec=0.
  - RR pointer=NREQ-1, so req[0] has first priority.
  - All counters=0.
- Reset mid-transaction aborts without a done pulse.
- IDLE:
  - If any req bit is set, pick the first set bit searching from pointer+1 with wrap-around.
  - Latch its req_data into the shift register, set gnt (one-hot) and pointer=winner.
  - Next state START.
  - No req: stay; all outputs 0.
- START (1 cycle): crc5_start=1, gnt held; next FEED.
- FEED (exactly DATA_W cycles):
  - s_in = latched bit[k] on cycle k, LSB first (bit 0 on the first FEED cycle).
  - bit counter 0..10; next WAIT_RDY.
  - s_in=0 in every state other than FEED.
- WAIT_RDY:
  - The watchdog counts from 0, cleared on state entry.
  - When crc5_ready=1, capture crc5_out in the same cycle and go to COLLECT.
  - Watchdog reaching TIMEOUT goes to ABORT.
- COLLECT:
  - Shift in one bit per cycle while crc5_ready=1, MSB first: the first captured bit lands in crc_out[4], the fifth in crc_out[0].
  - After 5 bits total, go to WAIT_DONE.
  - If crc5_ready drops before 5 bits, hold (no capture) and keep the watchdog running.
- WAIT_DONE:
  - When crc5_done=1, go to RELEASE.
  - Watchdog expiry goes to ABORT.
- RELEASE (1 cycle): crc5_rec=1; next RESP.
- RESP (1 cycle):
  - done[winner]=1 and crc_out valid.
  - gnt clears on the next cycle; next IDLE.
  - Back-to-back requests therefore see one IDLE cycle between transactions.
- ABORT (1 cycle):
  - crc5_rec=1 to force the engine to INIT.
  - crc_out=0 is loaded.
  - Next RESP with err=1 in that RESP cycle.
- req changes during a transaction, including the winner withdrawing, are ignored until IDLE.
- A new req never preempts.
- gnt and done are never asserted for more than one requester.
- Simultaneous requests resolve by RR: after serving i, the next search starts at i+1 mod NREQ.

Test Plan:
- Single request: req[0]=1, req_data[0]=11'h000 -> gnt=01, one crc5_start pulse, 11 s_in cycles all 0, then done[0] pulse with crc_out equal to the golden CRC5 model (poly x^5+x^2+1, init 11111, complemented); err=0.
- Field addr=7'h15, endp=4'hE (req_data=11'h715): s_in sequence equals the LSB-first bits 1,0,1,0,1,0,0,0,1,1,1 -> crc_out matches the golden model; exactly one crc5_rec pulse per transaction.
- Contention: req=11 held continuously for 4 transactions -> grant order 0,1,0,1; done pulses alternate; gnt is never 11.
- Watchdog, ready: engine stub never raises crc5_ready -> ABORT after TIMEOUT=32 cycles in WAIT_RDY, crc5_rec pulse, done+err pulse, crc_out=0, next request served normally.
- Watchdog, done: crc5_ready gaps mid-COLLECT (ready low for 3 cycles between bits 2 and 3) -> still 5 correct bits captured; crc5_done held low beyond TIMEOUT in WAIT_DONE -> err path taken.
- Reset mid-FEED: rst=1 at FEED cycle 5 -> next cycle all outputs 0, state IDLE, no done; a fresh request then completes correctly.
